// File: rtl/fetch_unit.sv
// fetch_unit: single-entry instruction fetch stage feeding decode from an icache.
// PC drives iaddr directly; a one-deep ins register decouples fetch from decode stalls.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        halt,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] npc,
  output logic [15:0] wait_cnt
);
  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [31:0] r_npc;
  logic        r_valid;
  logic [15:0] r_wait;
  logic        w_ren;
  logic        w_accept;
  logic [31:0] w_pc_inc;
  // iREN depends only on registered state and stall, never on ihit/iload
  assign w_ren     = (r_state == FETCH) && (!r_valid || !stall);
  assign w_accept  = w_ren && ihit;
  assign w_pc_inc  = r_pc + 32'd4;
  assign iREN      = w_ren;
  assign iaddr     = r_pc;
  assign ins       = r_ins;
  assign npc       = r_npc;
  assign ins_valid = r_valid;
  assign wait_cnt  = r_wait;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FETCH;
      r_pc    <= {PC_INIT[31:2], 2'b00};
      r_ins   <= '0;
      r_npc   <= '0;
      r_valid <= 1'b0;
      r_wait  <= '0;
    end else begin
      if (w_ren && !ihit && r_wait != 16'hFFFF)
        r_wait <= r_wait + 16'd1;
      if (r_state == FETCH) begin
        if (halt) begin
          r_state <= HALTED;
          r_valid <= 1'b0;
        end else if (redirect) begin
          r_pc    <= {target[31:2], 2'b00};
          r_valid <= 1'b0;
        end else if (w_accept) begin
          r_ins   <= iload;
          r_npc   <= w_pc_inc;
          r_valid <= 1'b1;
          r_pc    <= w_pc_inc;
        end else if (r_valid && !stall) begin
          r_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000, PC value loaded on reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 ihit  input  1  icache returns iload for the current iaddr this cycle.
REQ-005 iload  input  32  instruction word from icache.
REQ-006 stall  input  1  decode cannot accept ins this cycle.
REQ-007 redirect  input  1  branch/jump taken; load target into PC.
REQ-008 target  input  32  redirect PC value.
REQ-009 halt  input  1  decode unit has decoded a halt instruction.
REQ-010 iREN  output  1  instruction read request to icache.
REQ-011 iaddr  output  32  instruction fetch address (current PC).
REQ-012 ins  output  32  instruction word presented to decode unit.
REQ-013 ins_valid  output  1  ins holds a live instruction.
REQ-014 npc  output  32  address of ins plus 4.
REQ-015 wait_cnt  output  16  count of cycles iREN was high without ihit.

Function
REQ-016 State machine, two states: FETCH, HALTED.
REQ-017 iaddr SHALL always equal the PC register; PC bits [1:0] SHALL stay 0.
REQ-018 iREN = 1 only in FETCH and (!ins_valid or !stall); otherwise 0, combinationally.
REQ-019 Accept: in FETCH, iREN=1 and ihit=1 -> ins<=iload, npc<=PC+4, ins_valid<=1, PC<=PC+4 (mod 2^32, wraps 0xFFFFFFFC -> 0).
REQ-020 Consume without refill: ins_valid=1, stall=0, no accept -> ins_valid<=0; ins, npc hold.
REQ-021 Hold: ins_valid=1, stall=1 -> ins, npc, ins_valid, PC unchanged; ihit ignored.
REQ-022 Back-to-back: ins_valid=1, stall=0, ihit=1 -> new instruction loaded same cycle, one fetch per cycle sustained.
REQ-023 Redirect (FETCH): PC<=target, ins_valid<=0; coincident ihit/iload discarded, PC not incremented.
REQ-024 Halt (FETCH): state<=HALTED, ins_valid<=0; halt wins over coincident ihit.
REQ-025 Priority same cycle: RST > halt > redirect > accept/consume.
REQ-026 HALTED: iREN=0, ins_valid=0, PC frozen, redirect/ihit/stall ignored; exit only via RST.
REQ-027 wait_cnt increments by 1 each cycle iREN=1 and ihit=0; saturates at 16'hFFFF; never decrements.
REQ-028 No combinational path from ihit or iload to iREN or iaddr.

Reset
REQ-029 RST=1 at a clock edge -> state=FETCH, PC=PC_INIT, ins=0, npc=0, ins_valid=0, wait_cnt=0, from any state including mid-wait or HALTED.
REQ-030 iREN SHALL be 1 in the first cycle after RST deasserts.
REQ-031 Reset asserted while ihit=1 -> returned word discarded, PC=PC_INIT.

Verification
REQ-032 Reset, ihit=1 each cycle, stall=0, iload=PC-tagged words -> ins_valid=1 from cycle 1, iaddr 0,4,8,..., npc=iaddr of ins+4.
REQ-033 ihit held 0 for 3 cycles then 1 -> wait_cnt=3, ins_valid=0 during wait, ins=iload after hit, PC=4.
REQ-034 ins_valid=1, stall=1 for 4 cycles with ihit=1 -> iREN=0, ins/npc/PC unchanged; stall drop -> next fetch at held PC.
REQ-035 redirect=1, target=0x00000100, ihit=1 same cycle -> iaddr=0x100 next cycle, ins_valid=0, iload discarded.
REQ-036 halt=1 with redirect=1 and ihit=1 -> HALTED, iREN=0, ins_valid=0 forever; RST -> PC=PC_INIT, iREN=1.
REQ-037 Preload PC=0xFFFFFFFC via redirect, ihit=1 -> npc=0x00000000, next iaddr=0x00000000.
